xbar_rr_scheduler: RTL and testbench
====================================

// Module: xbar_rr_scheduler
// PURPOSE
//  Per-destination round-robin scheduler for the node-to-node crossbar network.
//  - Inputs: each source's head-of-FIFO packet (valid, dest).
//  - Per cycle, per destination: picks at most one source, pops that source FIFO, and
//    reports the winner one cycle later so the destination packet register captures it.
//  - Replaces fixed-priority selection with fair rotation; adds destination back-pressure.
// PARAMETERS
//  NUMNODES  8  number of nodes (sources = destinations); >=2
//  DEST_W    8  width of packet dest field; NUMNODES <= 2**DEST_W
// PORTS
//  clock       in   1                  sole clock; all state on posedge
//  reset       in   1                  asynchronous, active-high; clears all state
//  req_valid   in   NUMNODES           source i head packet valid (~empty)
//  req_dest    in   NUMNODES*DEST_W    dest field of source i head packet
//  dest_ready  in   NUMNODES           destination j can accept a packet this cycle
//  pop         out  NUMNODES           combinational; source i head consumed this cycle
//  sel_valid   out  NUMNODES           registered; destination j received a packet
//  sel_src     out  NUMNODES*DEST_W    registered; source index of that packet
//  err_dest    out  NUMNODES           sticky; source i presented dest >= NUMNODES
//  perf_grants out  NUMNODES*32        per-destination grant count (macro only)
//  perf_confl  out  NUMNODES*32        per-destination contention-cycle count (macro only)
// BEHAVIOUR
//  - Request: r[j][i] = req_valid[i] && req_dest[i]==j. A source requests at most one dest.
//  - Arbitration, per destination j, when dest_ready[j]==1:
//    - Winner = first i with r[j][i], searching ptr[j], ptr[j]+1, ... mod NUMNODES.
//  - Pointer: on a grant, ptr[j] <= (winner+1) mod NUMNODES.
//    - No grant (no requester or dest_ready[j]==0): ptr[j] holds.
//  - pop[i] = 1 iff source i won any destination; same cycle, no registering.
//  - Invalid dest (req_dest[i] >= NUMNODES, req_valid[i]==1):
//    - pop[i]=1 that cycle, so the packet is discarded and cannot deadlock the FIFO.
//    - err_dest[i] <= 1 and stays set until reset.
//    - No destination sees the packet.
//  - Output register, at each posedge, per destination j:
//    - Grant this cycle: sel_valid[j] <= 1, sel_src[j] <= winner.
//    - No grant: sel_valid[j] <= 0, sel_src[j] holds.
//  - Latency: grant decided in cycle N (pop in N); sel_valid/sel_src visible in N+1.
//  - dest_ready[j]==0: no grant for j, requesters are not popped, ptr[j] unchanged.
//  - Wrap: ptr at NUMNODES-1 that wins moves to 0.
//  - Reset (async, any time):
//    - ptr, sel_valid, sel_src, err_dest, perf counters -> 0.
//    - pop forced 0 while reset is high.
//    - In-flight grants are dropped; the source packet is not popped.
//  - Fairness: with a requester held and dest_ready high, it is granted within NUMNODES cycles.
// CONFIGURATION
//  XBAR_SCHED_PERF_EN defined:
//    - perf_grants[j] +1 on each grant to j.
//    - perf_confl[j] +1 on each cycle with >=2 requesters for j, regardless of dest_ready.
//    - Both saturate at 2**32-1 and clear only on reset.
//  XBAR_SCHED_PERF_EN undefined:
//    - No counter logic; perf_grants and perf_confl tied to 0. All other behaviour identical.
// TESTING (NUMNODES=4)
//  - Reset high mid-traffic -> pop=0 immediately; next cycle sel_valid=0, err_dest=0, ptr=0.
//  - src0,1,2 -> dest3 held valid, ready=1:
//    - sel_src[3] sequence 0,1,2,0 on consecutive cycles.
//    - Each pop pulses once per grant.
//  - src0->1, src1->2, src2->3, src3->0, all ready:
//    - pop=4'b1111 in one cycle.
//    - Next cycle sel_valid=4'b1111; sel_src[1..3,0] = 0,1,2,3.
//  - src2 -> dest1 with dest_ready[1]=0 for 3 cycles -> pop[2]=0, ptr[1] holds.
//    - ready rises -> pop[2]=1, sel_src[1]=2 one cycle later.
//  - src1 req_dest=9 -> pop[1]=1 that cycle, err_dest[1]=1 (sticky), sel_valid stays 0.
//  - PERF_EN on, src0,1 -> dest2 for 4 cycles, ready=1 -> perf_grants[2]=4, perf_confl[2]=4.

Source files
------------

// File: rtl/xbar_rr_scheduler.sv
// rtl/xbar_rr_scheduler.sv - per-destination round-robin crossbar scheduler (optional counters: XBAR_SCHED_PERF_EN)
module xbar_rr_scheduler #(
    parameter int NUMNODES = 8,
    parameter int DEST_W   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUMNODES-1:0]          req_valid,
    input  logic [NUMNODES*DEST_W-1:0]   req_dest,
    input  logic [NUMNODES-1:0]          dest_ready,
    output logic [NUMNODES-1:0]          pop,
    output logic [NUMNODES-1:0]          sel_valid,
    output logic [NUMNODES*DEST_W-1:0]   sel_src,
    output logic [NUMNODES-1:0]          err_dest,
    output logic [NUMNODES*32-1:0]       perf_grants,
    output logic [NUMNODES*32-1:0]       perf_confl
);

    localparam int PTR_W = $clog2(NUMNODES);

    logic [PTR_W-1:0]    ptr [NUMNODES];
    logic [PTR_W-1:0]    win [NUMNODES];
    logic [NUMNODES-1:0] req [NUMNODES];
    logic [NUMNODES-1:0] grant;
    logic [NUMNODES-1:0] bad;
    logic [NUMNODES-1:0] pop_raw;

    // req[j][i]: source i heads for destination j; bad[i]: dest out of range
    always_comb begin
        bad = '0;
        for (int j = 0; j < NUMNODES; j++) begin
            req[j] = '0;
        end
        for (int i = 0; i < NUMNODES; i++) begin
            bad[i] = req_valid[i] &&
                     ({1'b0, req_dest[i*DEST_W +: DEST_W]} >= (DEST_W+1)'(NUMNODES));
            for (int j = 0; j < NUMNODES; j++) begin
                req[j][i] = req_valid[i] && (req_dest[i*DEST_W +: DEST_W] == DEST_W'(j));
            end
        end
    end

    // Rotating search from ptr[j]; bad packets are popped so they cannot block a FIFO
    always_comb begin
        grant   = '0;
        pop_raw = bad;
        for (int j = 0; j < NUMNODES; j++) begin
            win[j] = '0;
            for (int k = 0; k < NUMNODES; k++) begin
                int idx;
                idx = int'(ptr[j]) + k;
                if (idx >= NUMNODES) begin
                    idx = idx - NUMNODES;
                end
                if (!grant[j] && dest_ready[j] && req[j][idx]) begin
                    grant[j]     = 1'b1;
                    win[j]       = PTR_W'(idx);
                    pop_raw[idx] = 1'b1;
                end
            end
        end
    end

    assign pop = reset ? '0 : pop_raw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUMNODES; j++) begin
                ptr[j] <= '0;
            end
            sel_valid <= '0;
            sel_src   <= '0;
            err_dest  <= '0;
        end else begin
            for (int j = 0; j < NUMNODES; j++) begin
                if (grant[j]) begin
                    ptr[j] <= (win[j] == PTR_W'(NUMNODES-1)) ? '0 : win[j] + 1'b1;
                    sel_src[j*DEST_W +: DEST_W] <= DEST_W'(win[j]);
                end
            end
            sel_valid <= grant;
            err_dest  <= err_dest | bad;
        end
    end

`ifdef XBAR_SCHED_PERF_EN
    logic [31:0]         grants_q [NUMNODES];
    logic [31:0]         confl_q  [NUMNODES];
    logic [NUMNODES-1:0] multi;

    // More than one bit set: clearing the lowest set bit leaves something
    always_comb begin
        multi = '0;
        for (int j = 0; j < NUMNODES; j++) begin
            multi[j] = (req[j] & (req[j] - 1'b1)) != '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUMNODES; j++) begin
                grants_q[j] <= '0;
                confl_q[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < NUMNODES; j++) begin
                if (grant[j] && grants_q[j] != '1) begin
                    grants_q[j] <= grants_q[j] + 32'd1;
                end
                if (multi[j] && confl_q[j] != '1) begin
                    confl_q[j] <= confl_q[j] + 32'd1;
                end
            end
        end
    end

    for (genvar j = 0; j < NUMNODES; j++) begin : g_perf
        assign perf_grants[j*32 +: 32] = grants_q[j];
        assign perf_confl[j*32 +: 32]  = confl_q[j];
    end
`else
    assign perf_grants = '0;
    assign perf_confl  = '0;
`endif

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// tb/tb_xbar_rr_scheduler.sv - directed self-checking bench for xbar_rr_scheduler
module tb_xbar_rr_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_dest;
    logic [3:0]  dest_ready;
    logic [3:0]  pop;
    logic [3:0]  sel_valid;
    logic [31:0] sel_src;
    logic [3:0]  err_dest;
    logic [127:0] perf_grants;
    logic [127:0] perf_confl;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_pop [4];
    logic [7:0] exp_src [4];

    xbar_rr_scheduler #(.NUMNODES(4), .DEST_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .dest_ready  (dest_ready),
        .pop         (pop),
        .sel_valid   (sel_valid),
        .sel_src     (sel_src),
        .err_dest    (err_dest),
        .perf_grants (perf_grants),
        .perf_confl  (perf_confl)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0001;
        req_dest   = {8'd0, 8'd0, 8'd0, 8'd3};
        dest_ready = 4'hF;
        #1;
        chk("rst_pop", 64'(pop), 64'h0);
        chk("rst_sel_valid", 64'(sel_valid), 64'h0);
        chk("rst_err", 64'(err_dest), 64'h0);
        chk("rst_sel_src", 64'(sel_src), 64'h0);
        cyc();
        @(negedge clock);
        reset = 1'b0;

        // src0,1,2 -> dest3: rotation 0,1,2,0
        exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        exp_src = '{8'd0, 8'd1, 8'd2, 8'd0};
        req_valid = 4'b0111;
        req_dest  = {8'd0, 8'd3, 8'd3, 8'd3};
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("rr_pop", 64'(pop), 64'(exp_pop[n]));
            cyc();
            chk("rr_sel_valid", 64'(sel_valid), 64'b1000);
            chk("rr_sel_src3", 64'(sel_src[31:24]), 64'(exp_src[n]));
        end

        req_valid = 4'b0000;
        #1;
        chk("idle_pop", 64'(pop), 64'h0);
        cyc();
        chk("idle_sel_valid", 64'(sel_valid), 64'h0);
        chk("idle_sel_src_hold", 64'(sel_src[31:24]), 64'd0);

        // permutation: every destination granted in one cycle
        req_valid = 4'b1111;
        req_dest  = {8'd0, 8'd3, 8'd2, 8'd1};
        #1;
        chk("perm_pop", 64'(pop), 64'hF);
        cyc();
        chk("perm_sel_valid", 64'(sel_valid), 64'hF);
        chk("perm_sel_src", 64'(sel_src), 64'({8'd2, 8'd1, 8'd0, 8'd3}));

        // ptr[0] wrapped from 3 to 0, so src0 beats src3
        req_valid = 4'b1001;
        req_dest  = {8'd0, 8'd0, 8'd0, 8'd0};
        #1;
        chk("wrap_pop", 64'(pop), 64'b0001);
        cyc();
        chk("wrap_sel_valid", 64'(sel_valid), 64'b0001);
        chk("wrap_sel_src0", 64'(sel_src[7:0]), 64'd0);

        // back-pressure on dest1
        req_valid  = 4'b0100;
        req_dest   = {8'd0, 8'd1, 8'd0, 8'd0};
        dest_ready = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_pop", 64'(pop), 64'h0);
            cyc();
            chk("bp_sel_valid", 64'(sel_valid), 64'h0);
        end
        dest_ready = 4'hF;
        #1;
        chk("bp_release_pop", 64'(pop), 64'b0100);
        cyc();
        chk("bp_release_valid", 64'(sel_valid), 64'b0010);
        chk("bp_release_src1", 64'(sel_src[15:8]), 64'd2);

        // invalid destinations: 9 and the boundary value 4
        req_valid = 4'b0010;
        req_dest  = {8'd0, 8'd0, 8'd9, 8'd0};
        #1;
        chk("bad9_pop", 64'(pop), 64'b0010);
        cyc();
        chk("bad9_sel_valid", 64'(sel_valid), 64'h0);
        chk("bad9_err", 64'(err_dest), 64'b0010);
        req_valid = 4'b1000;
        req_dest  = {8'd4, 8'd0, 8'd0, 8'd0};
        #1;
        chk("bad4_pop", 64'(pop), 64'b1000);
        cyc();
        chk("bad4_sel_valid", 64'(sel_valid), 64'h0);
        chk("bad4_err", 64'(err_dest), 64'b1010);
        req_valid = 4'b0000;
        cyc();
        chk("err_sticky", 64'(err_dest), 64'b1010);

        // ptr[3] is 3 here: search 3,0 picks src0 and moves ptr[3] to 1
        req_valid = 4'b0111;
        req_dest  = {8'd0, 8'd3, 8'd3, 8'd3};
        #1;
        chk("pre_rst_pop", 64'(pop), 64'b0001);
        cyc();
        chk("pre_rst_src3", 64'(sel_src[31:24]), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pop", 64'(pop), 64'h0);
        chk("midrst_sel_valid", 64'(sel_valid), 64'h0);
        chk("midrst_err", 64'(err_dest), 64'h0);
        cyc();
        chk("midrst_next_valid", 64'(sel_valid), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_pop", 64'(pop), 64'b0001);
        cyc();
        chk("post_rst_valid", 64'(sel_valid), 64'b1000);
        chk("post_rst_src3", 64'(sel_src[31:24]), 64'd0);

        // src0,1 -> dest2 for four cycles
        exp_pop   = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        req_valid = 4'b0011;
        req_dest  = {8'd0, 8'd0, 8'd2, 8'd2};
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("perf_pop", 64'(pop), 64'(exp_pop[n]));
            cyc();
        end
        req_valid = 4'b0000;
        #1;
`ifdef XBAR_SCHED_PERF_EN
        chk("perf_grants2", 64'(perf_grants[95:64]), 64'd4);
        chk("perf_confl2", 64'(perf_confl[95:64]), 64'd4);
`else
        chk("perf_grants_off", 64'(perf_grants[95:64]), 64'd0);
        chk("perf_confl_off", 64'(perf_confl[95:64]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
